// File: rtl/sha_msg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sha_msg_ctrl
// Description : Multi-block SHA-256 message sequencer. Accepts pre-padded
//               512-bit blocks, expands each into the 64-word message
//               schedule one word per cycle, launches the Pipe compression
//               datapath with the chaining value, captures the result as the
//               next chaining value and presents the final digest on a
//               valid/ready interface after the block flagged last.
// Ports       : clk, reset (async, active-high)
//               blk_valid/blk_ready/blk_data/blk_last  - block input
//               pipe_start/pipe_H_in/pipe_W            - Pipe launch
//               pipe_H_out/pipe_done                   - Pipe result
//               digest_valid/digest_ready/digest       - digest output
//               busy, err (sticky RUN timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module sha_msg_ctrl #(
  parameter logic [255:0] H_INIT  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19,
  parameter int unsigned  TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           blk_valid,
  output logic           blk_ready,
  input  logic [511:0]   blk_data,
  input  logic           blk_last,
  output logic           pipe_start,
  output logic [255:0]   pipe_H_in,
  output logic [2047:0]  pipe_W,
  input  logic [255:0]   pipe_H_out,
  input  logic           pipe_done,
  output logic           digest_valid,
  input  logic           digest_ready,
  output logic [255:0]   digest,
  output logic           busy,
  output logic           err
);

  localparam int unsigned            RUN_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_CNT_W-1:0]   RUN_LAST  = RUN_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_RUN    = 3'd2,
    S_CHAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   blk_ready_q;
  logic                   pipe_start_q;
  logic [255:0]           pipe_h_in_q;
  logic [31:0]            w_q [64];
  logic [5:0]             cnt_q;
  logic                   last_q;
  logic [RUN_CNT_W-1:0]   run_cnt_q;
  logic [255:0]           h_q;
  logic [255:0]           digest_q;
  logic                   digest_valid_q;
  logic                   err_q;

  logic                   w_accept;
  logic                   w_exp_done;
  logic                   w_done_hit;
  logic                   w_timeout_hit;
  logic [31:0]            w_new;

  function automatic logic [31:0] f_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_accept      = (state_q == S_IDLE) && blk_valid && blk_ready_q;
  assign w_exp_done    = (state_q == S_EXPAND) && (cnt_q == 6'd63);
  // The start cycle is excluded so a stale done from the previous block
  // (or a stuck-high done) can never be mistaken for this block's result.
  assign w_done_hit    = (state_q == S_RUN) && !pipe_start_q && pipe_done;
  assign w_timeout_hit = (state_q == S_RUN) && !w_done_hit && (run_cnt_q == RUN_LAST);

  // Schedule word t = cnt_q; 6-bit subtraction is safe since t >= 16 here.
  assign w_new = f_s1(w_q[cnt_q - 6'd2]) + w_q[cnt_q - 6'd7]
               + f_s0(w_q[cnt_q - 6'd15]) + w_q[cnt_q - 6'd16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_accept) state_d = S_EXPAND;
      S_EXPAND: if (w_exp_done) state_d = S_RUN;
      S_RUN: begin
        if (w_done_hit) begin
          state_d = S_CHAIN;
        end else if (w_timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_CHAIN:  state_d = last_q ? S_OUT : S_IDLE;
      S_OUT:    if (digest_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_ready_q    <= 1'b0;
      pipe_start_q   <= 1'b0;
      pipe_h_in_q    <= H_INIT;
      for (int i = 0; i < 64; i++) w_q[i] <= '0;
      cnt_q          <= '0;
      last_q         <= 1'b0;
      run_cnt_q      <= '0;
      h_q            <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // Registered so it stays low during the first cycle after reset.
      blk_ready_q  <= (state_d == S_IDLE);
      pipe_start_q <= w_exp_done;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < 16; i++) w_q[i] <= blk_data[511-32*i -: 32];
            for (int i = 16; i < 64; i++) w_q[i] <= '0;
            last_q <= blk_last;
            cnt_q  <= 6'd16;
          end
        end
        S_EXPAND: begin
          w_q[cnt_q] <= w_new;
          cnt_q      <= cnt_q + 6'd1;
          if (w_exp_done) run_cnt_q <= '0;
        end
        S_RUN: begin
          if (w_done_hit) begin
            h_q <= pipe_H_out;
          end else if (w_timeout_hit) begin
            // Abandon the message: the next block starts a fresh chain.
            err_q       <= 1'b1;
            pipe_h_in_q <= H_INIT;
            last_q      <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        S_CHAIN: begin
          if (last_q) begin
            digest_q       <= h_q;
            digest_valid_q <= 1'b1;
            pipe_h_in_q    <= H_INIT;
          end else begin
            pipe_h_in_q <= h_q;
          end
        end
        S_OUT: begin
          if (digest_ready) digest_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_pack_w
      assign pipe_W[2047-32*gi -: 32] = w_q[gi];
    end
  endgenerate

  assign blk_ready    = blk_ready_q;
  assign pipe_start   = pipe_start_q;
  assign pipe_H_in    = pipe_h_in_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha_msg_ctrl
// Description : Self-checking bench for sha_msg_ctrl with a behavioural
//               SHA-256 Pipe stub and a digest scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_msg_ctrl;

  localparam logic [255:0] H_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam int TMO = 16;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {448'h0, 64'h1c0};
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic           clk = 1'b0;
  logic           reset;
  logic           blk_valid;
  logic           blk_ready;
  logic [511:0]   blk_data;
  logic           blk_last;
  logic           pipe_start;
  logic [255:0]   pipe_H_in;
  logic [2047:0]  pipe_W;
  logic [255:0]   pipe_H_out;
  logic           pipe_done;
  logic           digest_valid;
  logic           digest_ready;
  logic [255:0]   digest;
  logic           busy;
  logic           err;

  sha_msg_ctrl #(.H_INIT(H_INIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .pipe_start(pipe_start), .pipe_H_in(pipe_H_in), .pipe_W(pipe_W),
    .pipe_H_out(pipe_H_out), .pipe_done(pipe_done),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0]  sb_q[$];        // expected digests
  logic [2047:0] w_exp_q[$];     // expected schedule per launched block
  bit            chained_q[$];   // 1: block must chain from previous Pipe result
  logic [255:0]  last_hout = '0;
  int            start_cnt = 0;
  int            stub_mode = 0;  // 0 normal, 1 never done, 2 done stuck high

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] b);
    logic [31:0]   w [64];
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) r[2047-32*t -: 32] = w[t];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [2047:0] wv);
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 8; i++) hv[i] = hin[255-32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + wv[2047-32*t -: 32];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipe stub: checks the launch, computes the compression and answers.
  initial begin : pipe_stub
    logic [2047:0] wexp;
    bit            chn;
    pipe_done  = 1'b0;
    pipe_H_out = '0;
    forever begin
      @(negedge clk);
      pipe_done = (stub_mode == 2);
      if (!reset && pipe_start) begin
        start_cnt++;
        n_cmp++;
        assert (w_exp_q.size() > 0) else begin
          n_bad++;
          $error("FAIL stub_start: observed=unexpected pipe_start expected=no launch");
        end
        if (w_exp_q.size() > 0) begin
          wexp = w_exp_q.pop_front();
          chn  = chained_q.pop_front();
          n_cmp++;
          assert (pipe_W === wexp) else begin
            n_bad++;
            for (int i = 0; i < 64; i++) begin
              if (pipe_W[2047-32*i -: 32] !== wexp[2047-32*i -: 32]) begin
                $error("FAIL pipe_W word %0d: observed=%h expected=%h", i,
                       pipe_W[2047-32*i -: 32], wexp[2047-32*i -: 32]);
                break;
              end
            end
          end
          chk256("pipe_H_in", pipe_H_in, chn ? last_hout : H_INIT);
        end
        last_hout  = compress(pipe_H_in, pipe_W);
        pipe_H_out = last_hout;
        if (stub_mode == 0) begin
          repeat (3) @(negedge clk);
          pipe_done = 1'b1;
          @(negedge clk);
          pipe_done = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk32({tag, " ctrl bits"}, 32'({blk_ready, pipe_start, digest_valid, busy, err}), 32'd0);
    chk256({tag, " pipe_H_in"}, pipe_H_in, H_INIT);
    chk256({tag, " digest"}, digest, 256'h0);
    n_cmp++;
    assert (pipe_W === '0) else begin
      n_bad++;
      $error("FAIL %s pipe_W: observed=nonzero(word0=%h) expected=0", tag, pipe_W[2047 -: 32]);
    end
  endtask

  task automatic send_block(input logic [511:0] d, input logic last, input bit chained, output int t_acc);
    int n = 0;
    w_exp_q.push_back(expand(d));
    chained_q.push_back(chained);
    @(negedge clk);
    blk_data  = d;
    blk_last  = last;
    blk_valid = 1'b1;
    while (blk_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    chk32("blk_ready wait", 32'(blk_ready), 32'd1);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    blk_data  = '0;
  endtask

  task automatic wait_start(output int t);
    int n = 0;
    while (pipe_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    chk32("pipe_start wait", 32'(pipe_start), 32'd1);
  endtask

  task automatic get_digest(input string tag, input int hold, output int t_dv);
    int n = 0;
    int bad = 0;
    logic [255:0] exp = 'x;
    logic [255:0] d0;
    while (digest_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    t_dv = cyc;
    chk32({tag, " digest_valid"}, 32'(digest_valid), 32'd1);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    chk256({tag, " digest"}, digest, exp);
    if (hold > 0) begin
      d0 = digest;
      repeat (hold) begin
        @(negedge clk);
        if (digest_valid !== 1'b1 || digest !== d0 || blk_ready !== 1'b0) bad++;
      end
      chk32({tag, " backpressure hold errors"}, 32'(bad), 32'd0);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk32({tag, " after take {dv,ready,busy}"}, 32'({digest_valid, blk_ready, busy}), 32'b010);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ta, ts, tdv, n;
    reset        = 1'b1;
    blk_valid    = 1'b0;
    blk_data     = '0;
    blk_last     = 1'b0;
    digest_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    chk32("blk_ready after reset", 32'(blk_ready), 32'd1);

    // Single-block "abc"
    sb_q.push_back(ABC_DIG);
    send_block(ABC_BLK, 1'b1, 1'b0, ta);
    wait_start(ts);
    chk32("accept->start latency", 32'(ts - ta), 32'd49);
    chk32("abc W16", pipe_W[2047-32*16 -: 32], 32'h61626380);
    chk32("abc W17", pipe_W[2047-32*17 -: 32], 32'h000f0000);
    get_digest("abc", 0, tdv);
    chk32("start->digest_valid latency", 32'(tdv - ts), 32'd5);

    // Two-block message with digest backpressure
    sb_q.push_back(TWO_DIG);
    send_block(TWO_B1, 1'b0, 1'b0, ta);
    send_block(TWO_B2, 1'b1, 1'b1, ta);
    get_digest("two_block", 20, tdv);
    chk32("start count after two_block", 32'(start_cnt), 32'd3);

    // Pipe never answers: timeout
    stub_mode = 1;
    send_block(ABC_BLK, 1'b1, 1'b0, ta);
    wait_start(ts);
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk32("start->err cycles", 32'(cyc - ts), 32'(TMO));
    chk32("after timeout {err,busy}", 32'({err, busy}), 32'b10);
    stub_mode = 0;
    sb_q.push_back(ABC_DIG);
    send_block(ABC_BLK, 1'b1, 1'b0, ta);
    get_digest("abc after timeout", 0, tdv);
    chk32("err sticky", 32'(err), 32'd1);

    // Reset in EXPAND of block 1, then full resend
    send_block(TWO_B1, 1'b0, 1'b0, ta);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk32("async reset busy", 32'(busy), 32'd0);
    w_exp_q.delete();
    chained_q.delete();
    @(negedge clk);
    check_reset_vals("mid-expand reset");
    reset = 1'b0;
    @(negedge clk);
    sb_q.push_back(TWO_DIG);
    send_block(TWO_B1, 1'b0, 1'b0, ta);
    send_block(TWO_B2, 1'b1, 1'b1, ta);
    get_digest("two_block resend", 0, tdv);

    // pipe_done stuck high from the start cycle
    stub_mode = 2;
    @(negedge clk);
    sb_q.push_back(ABC_DIG);
    send_block(ABC_BLK, 1'b1, 1'b0, ta);
    wait_start(ts);
    get_digest("abc stuck done", 0, tdv);
    chk32("stuck done start->digest_valid", 32'(tdv - ts), 32'd3);
    stub_mode = 0;
    repeat (3) @(negedge clk);
    chk32("total pipe_start pulses", 32'(start_cnt), 32'd8);
    chk32("scoreboard drained", 32'(sb_q.size() + w_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
